// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and line-format constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int unsigned UART_DATA_BITS            = 8;
  localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Ports: clk, rst (async active-high), d (async input), q (synchronized output).
// RESET_VAL sets the value both flops take in reset (idle level of the line).
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 serial receiver with a one-entry valid/ready output register.
// Ports: clk, rst (async active-high), rx_i (async serial line, idle high),
//        data_o (received byte, LSB first on the wire), valid_o / ready_i
//        (output handshake), frame_err_o (pulse: stop bit low),
//        overrun_o (pulse: completed byte dropped because output was full).
// data_o is held stable while valid_o is high; it feeds combinational logic.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_i,
  output logic [UART_DATA_BITS-1:0] data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      frame_err_o,
  output logic                      overrun_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = 3;

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(UART_DATA_BITS - 1);

  logic rx;
  logic rx_prev;

  rx_state_t                 state, state_d;
  logic [CNT_W-1:0]          cnt, cnt_d;
  logic [IDX_W-1:0]          bit_idx, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift, shift_d;
  logic                      deliver;
  logic                      frame_err_d;
  logic [UART_DATA_BITS-1:0] data_d;
  logic                      valid_d;
  logic                      overrun_d;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx_i),
    .q  (rx)
  );

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    bit_idx_d   = bit_idx;
    shift_d     = shift;
    deliver     = 1'b0;
    frame_err_d = 1'b0;
    data_d      = data_o;
    valid_d     = valid_o;
    overrun_d   = 1'b0;

    case (state)
      IDLE: begin
        // Edge-triggered so a line stuck low does not restart frames.
        if (rx_prev && !rx) begin
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_d = '0;
          if (!rx) begin
            bit_idx_d = '0;
            state_d   = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          shift_d   = {rx, shift[UART_DATA_BITS-1:1]};
          cnt_d     = '0;
          bit_idx_d = bit_idx + IDX_W'(1);
          if (bit_idx == LAST_BIT) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx) begin
            deliver = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Output slot: a delivery may replace a byte being accepted this cycle.
    if (deliver) begin
      if (!valid_o || ready_i) begin
        data_d  = shift;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_o && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      rx_prev     <= 1'b1;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      bit_idx     <= bit_idx_d;
      shift       <= shift_d;
      rx_prev     <= rx;
      data_o      <= data_d;
      valid_o     <= valid_d;
      frame_err_o <= frame_err_d;
      overrun_o   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte with CLKS_PER_BIT = 16.
module tb_uart_rx_byte;

  localparam int unsigned CLKS = 16;
  // Posedges from the start-bit falling edge on rx_i to the stop-sample edge:
  // 2 sync flops + 1 edge detect, half a bit to mid-start, then 9 full bits.
  localparam int unsigned LAT = 3 + CLKS / 2 + 9 * CLKS;

  typedef struct {
    int unsigned due;
    logic [7:0]  b;
    bit          ok;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_i = 1'b1;
  logic       ready_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       overrun_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (expected outputs after each posedge).
  int unsigned cyc = 0;
  frame_t      fq[$];
  frame_t      mf;
  logic        m_valid = 1'b0;
  logic [7:0]  m_data = 8'h00;
  logic        m_fe = 1'b0;
  logic        m_ov = 1'b0;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (rx_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o)
  );

  always #5 clk = ~clk;

  // Transaction-level model: each frame resolves at its stop-sample edge.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    m_fe = 1'b0;
    m_ov = 1'b0;
    if (rst) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      fq.delete();
    end else if (fq.size() > 0 && fq[0].due == cyc) begin
      mf = fq.pop_front();
      if (!mf.ok) begin
        m_fe = 1'b1;
        if (m_valid && ready_i) m_valid = 1'b0;
      end else if (!m_valid || ready_i) begin
        m_data  = mf.b;
        m_valid = 1'b1;
      end else begin
        m_ov = 1'b1;
      end
    end else if (m_valid && ready_i) begin
      m_valid = 1'b0;
    end
  end

  // Must be called at a negedge; returns at a negedge.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    frame_t f;
    logic [9:0] bits;
    f.due = cyc + LAT;
    f.b   = b;
    f.ok  = stop_ok;
    fq.push_back(f);
    bits = {stop_ok, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_i = bits[k];
      repeat (CLKS) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_i = 1'b1;
    ready_i = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", data_o); end
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_o); end
    n_checks++; if (frame_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got %b want 0", frame_err_o); end
    n_checks++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovr got %b want 0", overrun_o); end
    rst = 1'b0;
    idle(4);
  endtask

  task automatic test_normal();
    bit done = 0;
    int vcount = 0;
    logic [7:0] got = 8'hxx;
    ready_i = 1'b1;
    fork
      begin send_frame(8'h61, 1'b1); idle(4); done = 1; end
      while (!done) begin
        @(negedge clk);
        if (valid_o) begin vcount++; got = data_o; end
        n_checks++;
        if ({valid_o, frame_err_o, overrun_o, data_o} !== {m_valid, m_fe, m_ov, m_data}) begin
          n_fail++;
          $display("FAIL normal_cyc t=%0t got v%b f%b o%b d%h want v%b f%b o%b d%h", $time,
                   valid_o, frame_err_o, overrun_o, data_o, m_valid, m_fe, m_ov, m_data);
        end
      end
    join
    n_checks++; if (got !== 8'h61) begin n_fail++; $display("FAIL normal_data got %h want 61", got); end
    n_checks++; if (vcount != 1) begin n_fail++; $display("FAIL normal_valid_cycles got %0d want 1", vcount); end
  endtask

  task automatic test_glitch();
    bit done = 0;
    int vcount = 0;
    int fcount = 0;
    logic [7:0] got = 8'hxx;
    ready_i = 1'b1;
    fork
      begin
        rx_i = 1'b0;
        repeat (4) @(negedge clk);
        idle(3 * CLKS);
        send_frame(8'h7A, 1'b1);
        idle(4);
        done = 1;
      end
      while (!done) begin
        @(negedge clk);
        if (valid_o) begin vcount++; got = data_o; end
        if (frame_err_o) fcount++;
        n_checks++;
        if ({valid_o, frame_err_o, overrun_o, data_o} !== {m_valid, m_fe, m_ov, m_data}) begin
          n_fail++;
          $display("FAIL glitch_cyc t=%0t got v%b f%b o%b d%h want v%b f%b o%b d%h", $time,
                   valid_o, frame_err_o, overrun_o, data_o, m_valid, m_fe, m_ov, m_data);
        end
      end
    join
    n_checks++; if (vcount != 1) begin n_fail++; $display("FAIL glitch_valid_cycles got %0d want 1", vcount); end
    n_checks++; if (fcount != 0) begin n_fail++; $display("FAIL glitch_ferr got %0d want 0", fcount); end
    n_checks++; if (got !== 8'h7A) begin n_fail++; $display("FAIL glitch_next_data got %h want 7a", got); end
  endtask

  task automatic test_bad_stop();
    bit done = 0;
    int vcount = 0;
    int fcount = 0;
    logic [7:0] got = 8'hxx;
    ready_i = 1'b1;
    fork
      begin
        send_frame(8'h41, 1'b0);
        idle(CLKS);
        send_frame(8'h4A, 1'b1);
        idle(4);
        done = 1;
      end
      while (!done) begin
        @(negedge clk);
        if (valid_o) begin vcount++; got = data_o; end
        if (frame_err_o) fcount++;
        n_checks++;
        if ({valid_o, frame_err_o, overrun_o, data_o} !== {m_valid, m_fe, m_ov, m_data}) begin
          n_fail++;
          $display("FAIL badstop_cyc t=%0t got v%b f%b o%b d%h want v%b f%b o%b d%h", $time,
                   valid_o, frame_err_o, overrun_o, data_o, m_valid, m_fe, m_ov, m_data);
        end
      end
    join
    n_checks++; if (fcount != 1) begin n_fail++; $display("FAIL badstop_ferr_pulses got %0d want 1", fcount); end
    n_checks++; if (vcount != 1) begin n_fail++; $display("FAIL badstop_valid_cycles got %0d want 1", vcount); end
    n_checks++; if (got !== 8'h4A) begin n_fail++; $display("FAIL badstop_next_data got %h want 4a", got); end
  endtask

  task automatic test_overrun();
    bit done = 0;
    int ocount = 0;
    ready_i = 1'b0;
    fork
      begin send_frame(8'h62, 1'b1); send_frame(8'h63, 1'b1); idle(2); done = 1; end
      while (!done) begin
        @(negedge clk);
        if (overrun_o) ocount++;
        n_checks++;
        if ({valid_o, frame_err_o, overrun_o, data_o} !== {m_valid, m_fe, m_ov, m_data}) begin
          n_fail++;
          $display("FAIL overrun_cyc t=%0t got v%b f%b o%b d%h want v%b f%b o%b d%h", $time,
                   valid_o, frame_err_o, overrun_o, data_o, m_valid, m_fe, m_ov, m_data);
        end
      end
    join
    n_checks++; if (ocount != 1) begin n_fail++; $display("FAIL overrun_pulses got %0d want 1", ocount); end
    n_checks++; if (data_o !== 8'h62 || valid_o !== 1'b1) begin
      n_fail++; $display("FAIL overrun_hold got v%b d%h want v1 d62", valid_o, data_o); end
    ready_i = 1'b1;
    @(negedge clk);
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL overrun_clear got %b want 0", valid_o); end
  endtask

  task automatic test_back_to_back();
    bit done = 0;
    int ocount = 0;
    int unsigned due64;
    ready_i = 1'b0;
    fork
      begin
        send_frame(8'h63, 1'b1);
        due64 = cyc + LAT;
        fork
          send_frame(8'h64, 1'b1);
          begin
            wait (cyc == due64 - 1);
            @(negedge clk); ready_i = 1'b1;
            @(negedge clk); ready_i = 1'b0;
          end
        join
        idle(2);
        done = 1;
      end
      while (!done) begin
        @(negedge clk);
        if (overrun_o) ocount++;
        n_checks++;
        if ({valid_o, frame_err_o, overrun_o, data_o} !== {m_valid, m_fe, m_ov, m_data}) begin
          n_fail++;
          $display("FAIL b2b_cyc t=%0t got v%b f%b o%b d%h want v%b f%b o%b d%h", $time,
                   valid_o, frame_err_o, overrun_o, data_o, m_valid, m_fe, m_ov, m_data);
        end
      end
    join
    n_checks++; if (ocount != 0) begin n_fail++; $display("FAIL b2b_overrun got %0d want 0", ocount); end
    n_checks++; if (data_o !== 8'h64 || valid_o !== 1'b1) begin
      n_fail++; $display("FAIL b2b_swap got v%b d%h want v1 d64", valid_o, data_o); end
    ready_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    bit done = 0;
    int vcount = 0;
    logic [7:0] got = 8'hxx;
    logic [7:0] b = 8'hA5;
    ready_i = 1'b0;
    send_frame(8'h55, 1'b1);
    idle(2);
    rx_i = 1'b0;
    repeat (CLKS) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      rx_i = b[k];
      repeat (CLKS) @(negedge clk);
    end
    rx_i = b[4];
    repeat (CLKS / 2) @(negedge clk);
    n_checks++; if (valid_o !== 1'b1 || data_o !== 8'h55) begin
      n_fail++; $display("FAIL rstmid_pre got v%b d%h want v1 d55", valid_o, data_o); end
    rst = 1'b1;
    #1;
    n_checks++; if ({valid_o, frame_err_o, overrun_o, data_o} !== 11'h0) begin
      n_fail++; $display("FAIL rstmid_async got v%b f%b o%b d%h want all 0", valid_o, frame_err_o, overrun_o, data_o); end
    rx_i = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ready_i = 1'b1;
    idle(4);
    fork
      begin send_frame(8'h7B, 1'b1); idle(4); done = 1; end
      while (!done) begin
        @(negedge clk);
        if (valid_o) begin vcount++; got = data_o; end
        n_checks++;
        if ({valid_o, frame_err_o, overrun_o, data_o} !== {m_valid, m_fe, m_ov, m_data}) begin
          n_fail++;
          $display("FAIL rstmid_cyc t=%0t got v%b f%b o%b d%h want v%b f%b o%b d%h", $time,
                   valid_o, frame_err_o, overrun_o, data_o, m_valid, m_fe, m_ov, m_data);
        end
      end
    join
    n_checks++; if (got !== 8'h7B || vcount != 1) begin
      n_fail++; $display("FAIL rstmid_next got d%h x%0d want d7b x1", got, vcount); end
  endtask

  task automatic test_random();
    bit done = 0;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          bit ok;
          ok = ($urandom_range(0, 5) != 0);
          send_frame(8'($urandom_range(0, 255)), ok);
          if (!ok) idle(CLKS);
          idle($urandom_range(0, 3));
        end
        idle(4);
        done = 1;
      end
      while (!done) begin
        @(negedge clk);
        ready_i = 1'($urandom_range(0, 1));
      end
      while (!done) begin
        @(negedge clk);
        n_checks++;
        if ({valid_o, frame_err_o, overrun_o, data_o} !== {m_valid, m_fe, m_ov, m_data}) begin
          n_fail++;
          $display("FAIL random_cyc t=%0t got v%b f%b o%b d%h want v%b f%b o%b d%h", $time,
                   valid_o, frame_err_o, overrun_o, data_o, m_valid, m_fe, m_ov, m_data);
        end
      end
    join
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t simulation did not complete", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_normal();
    test_glitch();
    test_bad_stop();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
